// File: rtl/m_axis_rc_dw_split_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : m_axis_rc_dw_split_if
//  Description : AXI4-Stream bundle (data, keep, last, user, valid, ready)
//                with master/slave views. READY_WIDTH allows a replicated
//                ready vector on the legacy completion side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface m_axis_rc_dw_split_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int USER_WIDTH  = 85,
    parameter int READY_WIDTH = 1
);
    localparam int c_KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]   tdata;
    logic [c_KEEP_WIDTH-1:0] tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic [READY_WIDTH-1:0]  tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input  tready);
    modport slave  (input  tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/m_axis_rc_dw_split.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : m_axis_rc_dw_split
//  Description : Splits each 256-bit legacy RC completion beat into one or
//                two 128-bit output beats. The upper half is skipped when its
//                keep is all-zero. One-beat buffer, registered outputs, full
//                AXIS backpressure with no bubble between beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_axis_rc_dw_split #(
    parameter int IN_DATA_WIDTH  = 256,
    parameter int OUT_DATA_WIDTH = 128,
    parameter int USER_WIDTH     = 85
) (
    input  wire                   user_clk,
    input  wire                   user_reset_n,
    m_axis_rc_dw_split_if.slave   s_axis_rc,
    m_axis_rc_dw_split_if.master  m_axis
);
    localparam int c_IN_KEEP_W  = IN_DATA_WIDTH / 8;
    localparam int c_OUT_KEEP_W = OUT_DATA_WIDTH / 8;
    localparam int c_READY_W    = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOWER = 2'd1,
        ST_UPPER = 2'd2
    } state_t;

    state_t                     state_q,  state_d;
    logic [IN_DATA_WIDTH-1:0]   data_q,   data_d;
    logic [c_IN_KEEP_W-1:0]     keep_q,   keep_d;
    logic                       last_q,   last_d;
    logic [USER_WIDTH-1:0]      user_q,   user_d;

    logic [OUT_DATA_WIDTH-1:0]  tdata_q,  tdata_d;
    logic [c_OUT_KEEP_W-1:0]    tkeep_q,  tkeep_d;
    logic                       tlast_q,  tlast_d;
    logic [USER_WIDTH-1:0]      tuser_q,  tuser_d;
    logic                       tvalid_q, tvalid_d;

    logic w_upper_empty;
    logic w_out_accept;
    logic w_beat_done;
    logic w_in_ready;
    logic w_in_accept;
    logic w_in_upper_empty;

    // Handshake decode: the buffer can refill in the same cycle its last half leaves.
    always_comb begin
        w_upper_empty    = (keep_q[c_IN_KEEP_W-1:c_OUT_KEEP_W] == '0);
        w_in_upper_empty = (s_axis_rc.tkeep[c_IN_KEEP_W-1:c_OUT_KEEP_W] == '0);
        w_out_accept     = tvalid_q & m_axis.tready;
        w_beat_done      = w_out_accept &
                           ((state_q == ST_UPPER) | ((state_q == ST_LOWER) & w_upper_empty));
        w_in_ready       = (state_q == ST_EMPTY) | w_beat_done;
        w_in_accept      = s_axis_rc.tvalid & w_in_ready;
    end

    // Next-state and next-output selection; everything holds unless a handshake occurs.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        keep_d   = keep_q;
        last_d   = last_q;
        user_d   = user_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;

        if (w_in_accept) begin
            // Load a new beat and present its lower half straight away.
            state_d  = ST_LOWER;
            data_d   = s_axis_rc.tdata;
            keep_d   = s_axis_rc.tkeep;
            last_d   = s_axis_rc.tlast;
            user_d   = s_axis_rc.tuser;
            tdata_d  = s_axis_rc.tdata[OUT_DATA_WIDTH-1:0];
            tkeep_d  = s_axis_rc.tkeep[c_OUT_KEEP_W-1:0];
            tlast_d  = s_axis_rc.tlast & w_in_upper_empty;
            tuser_d  = s_axis_rc.tuser;
            tvalid_d = 1'b1;
        end else if (w_out_accept) begin
            if ((state_q == ST_LOWER) && !w_upper_empty) begin
                state_d = ST_UPPER;
                tdata_d = data_q[IN_DATA_WIDTH-1:OUT_DATA_WIDTH];
                tkeep_d = keep_q[c_IN_KEEP_W-1:c_OUT_KEEP_W];
                tlast_d = last_q;
                tuser_d = user_q;
            end else begin
                state_d  = ST_EMPTY;
                tvalid_d = 1'b0;
            end
        end
    end

    // State, beat buffer and output registers.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            user_q   <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
            last_q   <= last_d;
            user_q   <= user_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign s_axis_rc.tready = {c_READY_W{w_in_ready}};
    assign m_axis.tdata     = tdata_q;
    assign m_axis.tkeep     = tkeep_q;
    assign m_axis.tlast     = tlast_q;
    assign m_axis.tuser     = tuser_q;
    assign m_axis.tvalid    = tvalid_q;

endmodule
`default_nettype wire

// File: doc/m_axis_rc_dw_split.md
Name: m_axis_rc_dw_split

Overview:
- Downstream stage of the RC completion adapter. Consumes its legacy-format 256-bit completion stream and re-emits it as a 128-bit stream for the 128-bit TLP receive path.
- Each input beat is held in a one-beat buffer and split into a lower half and an upper half. The upper half is dropped when its keep is all-zero.
- Provides real AXIS backpressure: registered outputs, one-beat buffering.

Parameters:
- IN_DATA_WIDTH, 256, input data width; fixed at 256.
- OUT_DATA_WIDTH, 128, output data width; must equal IN_DATA_WIDTH/2.
- USER_WIDTH, 85, sideband width, passed through unchanged.

Ports:
- user_clk  in  1  block clock.
- user_reset_n  in  1  asynchronous, active-low reset.
- s_axis_rc_tdata  in  256  legacy-format completion data; header in [127:0] on the first beat.
- s_axis_rc_tkeep  in  32  byte enables.
- s_axis_rc_tlast  in  1  end of TLP.
- s_axis_rc_tuser  in  85  sideband (err_fwd, discontinue, ...).
- s_axis_rc_tvalid  in  1  input valid.
- s_axis_rc_tready  out  4  input ready; all four bits are identical.
- m_axis_tdata  out  128  output data.
- m_axis_tkeep  out  16  output byte enables.
- m_axis_tlast  out  1  end of TLP.
- m_axis_tuser  out  85  sideband.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- Reset (user_reset_n low, asynchronous assert, synchronous release):
  - buf_full=0, half=0.
  - m_axis_tvalid=0; m_axis_tdata, tkeep, tlast and tuser all 0.
  - Reset mid-packet discards the held beat; no partial half is emitted after release.
- Handshake:
  - A transfer occurs on tvalid&tready.
  - m_axis_tvalid, once high, holds with stable data/keep/last/user until accepted.
  - Input is accepted only when s_axis_rc_tready is high.
- Buffer: one 256-bit beat register plus keep/last/user, buf_full flag, and half pointer (0 = lower, 1 = upper).
  - upper_empty = (held tkeep[31:16] == 0).
- Output mux, registered:
  - half=0: tdata=held[127:0], tkeep=held_keep[15:0], tlast=held_last & upper_empty.
  - half=1: tdata=held[255:128], tkeep=held_keep[31:16], tlast=held_last.
  - tuser=held_user on both halves.
- FSM states: EMPTY, LOWER, UPPER.
  - EMPTY: on input accept, load buffer and go to LOWER. m_axis_tvalid rises the next cycle (latency 1 clock).
  - LOWER, on output accept:
    - if !upper_empty, go to UPPER;
    - else the beat is finished: reload if an input is accepted the same cycle (stay LOWER), otherwise go to EMPTY.
  - UPPER, on output accept: the beat is finished; reload-or-EMPTY as above.
- s_axis_rc_tready = EMPTY | (beat finishes this cycle). This is combinational from m_axis_tready and state, with no bubble between beats.
- Throughput: one 128-bit output per clock under continuous tready.
- A beat with all-zero keep (illegal upstream) still emits its lower half with tkeep=0. No error is flagged.
- tlast on a beat whose upper half is non-empty appears only on the upper output beat.
- Simultaneous output-finish and input-valid: the new beat loads in the same cycle; no data loss, no duplication.
- m_axis_tready low: all state frozen; input is stalled once the buffer is full.

Test Plan:
- Single-beat TLP, tkeep=0xFFFFFFFF, tlast=1, data[255:128]=B, [127:0]=A:
  - output beat 1: A, tkeep=0xFFFF, tlast=0;
  - output beat 2: B, tkeep=0xFFFF, tlast=1;
  - first output valid 1 clock after input accept.
- Three-beat TLP, last beat tkeep=0x0000000F:
  - exactly 5 output beats;
  - final beat tkeep=0x000F, tlast=1;
  - s_axis_rc_tready low on every LOWER cycle whose upper half is pending.
- Continuous input with m_axis_tready=1:
  - output valid every cycle with no gap between beats;
  - input accepted every second cycle when all keeps are full.
- Random m_axis_tready (~50%) over 200 TLPs with random lengths and keeps:
  - reassembled output bytes, tlast positions and tuser match a scoreboard exactly;
  - outputs stay stable while stalled.
- Reset asserted while in UPPER with m_axis_tready=0:
  - m_axis_tvalid=0 immediately (asynchronously);
  - after release, the next TLP emerges intact with no stale half.
- tuser[1]=1 (err_fwd) on a first beat with full keep: both output halves carry tuser[1]=1.
